// File: rtl/rf_pkg.sv
// Shared constants and types for the core register file: port counts,
// default geometry and the reserved IP/FLAGS register addresses.
package rf_pkg;

    localparam int RF_ADDR_BITS    = 5;
    localparam int RF_WORD_BITS    = 32;

    localparam int NUM_AB_PORTS    = 4;
    localparam int NUM_WRITE_PORTS = 4;
    localparam int NUM_C_PORTS     = 2;

    localparam int RF_IP_INDEX     = 2**RF_ADDR_BITS - 1;
    localparam int RF_FLAGS_INDEX  = 2**RF_ADDR_BITS - 2;

    typedef logic [RF_ADDR_BITS-1:0] reg_addr_t;
    typedef logic [RF_WORD_BITS-1:0] word_t;

endpackage : rf_pkg

// File: rtl/rf_32x_regfile_if.sv
// Bundle of read/write port signals between the issue lanes (master) and
// the register file (slave).
interface rf_32x_regfile_if
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = RF_ADDR_BITS,
    parameter int WORD_WIDTH    = RF_WORD_BITS
);

    logic [NUM_AB_PORTS-1:0][ADDRESS_WIDTH-1:0]    select_a_i;
    logic [NUM_AB_PORTS-1:0][ADDRESS_WIDTH-1:0]    select_b_i;
    logic [NUM_C_PORTS-1:0][ADDRESS_WIDTH-1:0]     select_c_i;
    logic [NUM_WRITE_PORTS-1:0][ADDRESS_WIDTH-1:0] select_r_i;
    logic [NUM_WRITE_PORTS-1:0][WORD_WIDTH-1:0]    data_i;
    logic [NUM_WRITE_PORTS-1:0]                    enable_writing_i;
    logic [WORD_WIDTH-1:0]                         flags_i;

    logic [NUM_AB_PORTS-1:0][WORD_WIDTH-1:0]       a_o;
    logic [NUM_AB_PORTS-1:0][WORD_WIDTH-1:0]       b_o;
    logic [NUM_C_PORTS-1:0][WORD_WIDTH-1:0]        c_o;
    logic [WORD_WIDTH-1:0]                         instr_ptr_o;
    logic [WORD_WIDTH-1:0]                         flags_o;

    modport master (
        output select_a_i, select_b_i, select_c_i,
        output select_r_i, data_i, enable_writing_i, flags_i,
        input  a_o, b_o, c_o, instr_ptr_o, flags_o
    );

    modport slave (
        input  select_a_i, select_b_i, select_c_i,
        input  select_r_i, data_i, enable_writing_i, flags_i,
        output a_o, b_o, c_o, instr_ptr_o, flags_o
    );

endinterface : rf_32x_regfile_if

// File: rtl/rf_write_arbiter.sv
// Per-register write reduction: collapses the four R ports into one enable
// and data word, higher-numbered ports overriding lower ones.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = RF_ADDR_BITS,
    parameter int WORD_WIDTH    = RF_WORD_BITS,
    parameter int REG_INDEX     = 0,
    parameter bit TRACK_FLAGS   = 1'b0
) (
    input  logic [NUM_WRITE_PORTS-1:0][ADDRESS_WIDTH-1:0] select_r,
    input  logic [NUM_WRITE_PORTS-1:0][WORD_WIDTH-1:0]    data,
    input  logic [NUM_WRITE_PORTS-1:0]                    enable_writing,
    input  logic [WORD_WIDTH-1:0]                         flags,
    output logic                                          write_enable,
    output logic [WORD_WIDTH-1:0]                         write_data
);

    localparam logic [ADDRESS_WIDTH-1:0] MY_ADDR = REG_INDEX[ADDRESS_WIDTH-1:0];

    logic [NUM_WRITE_PORTS-1:0] hit;

    always_comb begin
        for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
            hit[k] = enable_writing[k] && (select_r[k] == MY_ADDR);
        end
    end

    // The flags register reloads from the ALU every cycle unless a port
    // claims it; ascending scan lets later (higher) ports overwrite.
    always_comb begin
        write_enable = TRACK_FLAGS;
        write_data   = TRACK_FLAGS ? flags : '0;
        for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
            if (hit[k]) begin
                write_enable = 1'b1;
                write_data   = data[k];
            end
        end
    end

endmodule : rf_write_arbiter

// File: rtl/rf_32x_regfile.sv
// Multi-ported general register file: ten combinational read ports, four
// prioritised write ports, and in-file IP and FLAGS registers.
module rf_32x_regfile
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = RF_ADDR_BITS,
    parameter int WORD_WIDTH    = RF_WORD_BITS,
    parameter int IP_INDEX      = 2**ADDRESS_WIDTH - 1,
    parameter int FLAGS_INDEX   = 2**ADDRESS_WIDTH - 2
) (
    input  logic             clk_i,
    input  logic             arst_i,
    rf_32x_regfile_if.slave  bus
);

    localparam int NUM_REGS = 2**ADDRESS_WIDTH;

    logic [WORD_WIDTH-1:0] regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0]   reg_we;
    logic [WORD_WIDTH-1:0] reg_wdata [NUM_REGS];

    genvar gi;

    // One arbiter and one storage word per register; the array of flops
    // is kept (not RAM) because every word is read combinationally.
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            rf_write_arbiter #(
                .ADDRESS_WIDTH (ADDRESS_WIDTH),
                .WORD_WIDTH    (WORD_WIDTH),
                .REG_INDEX     (gi),
                .TRACK_FLAGS   (gi == FLAGS_INDEX)
            ) u_arb (
                .select_r       (bus.select_r_i),
                .data           (bus.data_i),
                .enable_writing (bus.enable_writing_i),
                .flags          (bus.flags_i),
                .write_enable   (reg_we[gi]),
                .write_data     (reg_wdata[gi])
            );

            always_ff @(posedge clk_i or posedge arst_i) begin
                if (arst_i) begin
                    regs_reg[gi] <= '0;
                end else if (reg_we[gi]) begin
                    regs_reg[gi] <= reg_wdata[gi];
                end
            end
        end
    endgenerate

    generate
        for (gi = 0; gi < NUM_AB_PORTS; gi++) begin : g_read_ab
            assign bus.a_o[gi] = regs_reg[bus.select_a_i[gi]];
            assign bus.b_o[gi] = regs_reg[bus.select_b_i[gi]];
        end
        for (gi = 0; gi < NUM_C_PORTS; gi++) begin : g_read_c
            assign bus.c_o[gi] = regs_reg[bus.select_c_i[gi]];
        end
    endgenerate

    assign bus.instr_ptr_o = regs_reg[IP_INDEX];
    assign bus.flags_o     = regs_reg[FLAGS_INDEX];

endmodule : rf_32x_regfile

// File: tb/tb_rf_32x_regfile.sv
// Self-checking bench for rf_32x_regfile: directed vector table, async reset
// sequence, then randomized traffic against an array model.
module tb_rf_32x_regfile;

    localparam int AW = 5;
    localparam int WW = 32;
    localparam int IPX = 31;
    localparam int FLX = 30;

    logic clk;
    logic arst;

    rf_32x_regfile_if #(.ADDRESS_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

    rf_32x_regfile #(.ADDRESS_WIDTH(AW), .WORD_WIDTH(WW)) dut (
        .clk_i  (clk),
        .arst_i (arst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vectors;
    int n_miscompares;

    typedef struct packed {
        logic [3:0]        en;
        logic [3:0][4:0]   sel_r;
        logic [3:0][31:0]  data;
        logic [31:0]       flags;
        logic [3:0][4:0]   sel_a;
        logic [3:0][31:0]  exp_a;
        logic [31:0]       exp_flags;
        logic [31:0]       exp_ip;
    } vec_t;

    vec_t vecs [8];
    logic [31:0] model [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [3:0] en,
        input int r0, input int r1, input int r2, input int r3,
        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3,
        input logic [31:0] fl,
        input int a0, input int a1, input int a2, input int a3,
        input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3,
        input logic [31:0] ef, input logic [31:0] eip);
        vec_t v;
        v.en        = en;
        v.sel_r     = {r3[4:0], r2[4:0], r1[4:0], r0[4:0]};
        v.data      = {d3, d2, d1, d0};
        v.flags     = fl;
        v.sel_a     = {a3[4:0], a2[4:0], a1[4:0], a0[4:0]};
        v.exp_a     = {e3, e2, e1, e0};
        v.exp_flags = ef;
        v.exp_ip    = eip;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.enable_writing_i = '0;
        bus.select_r_i = '0;
        bus.data_i     = '0;
        bus.flags_i    = '0;
        bus.select_a_i = '0;
        bus.select_b_i = '0;
        bus.select_c_i = '0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 4; k++) chk($sformatf("%s a_o[%0d]", tag, k), bus.a_o[k], 32'h0);
        chk({tag, " instr_ptr_o"}, bus.instr_ptr_o, 32'h0);
        chk({tag, " flags_o"}, bus.flags_o, 32'h0);
    endtask

    // Read every port with fresh random selects and compare against the model.
    task automatic check_model_reads(input int iter);
        for (int k = 0; k < 4; k++) begin
            bus.select_a_i[k] = 5'($urandom_range(0, 31));
            bus.select_b_i[k] = 5'($urandom_range(0, 31));
        end
        for (int k = 0; k < 2; k++) bus.select_c_i[k] = 5'($urandom_range(0, 31));
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rnd%0d a_o[%0d]", iter, k), bus.a_o[k], model[bus.select_a_i[k]]);
            chk($sformatf("rnd%0d b_o[%0d]", iter, k), bus.b_o[k], model[bus.select_b_i[k]]);
        end
        for (int k = 0; k < 2; k++)
            chk($sformatf("rnd%0d c_o[%0d]", iter, k), bus.c_o[k], model[bus.select_c_i[k]]);
        chk($sformatf("rnd%0d instr_ptr_o", iter), bus.instr_ptr_o, model[IPX]);
        chk($sformatf("rnd%0d flags_o", iter), bus.flags_o, model[FLX]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vectors = 0;
        n_miscompares = 0;
        arst = 1'b0;
        idle_inputs();

        //            en      r0 r1 r2 r3  d0 d1 d2 d3                     flags    a0 a1 a2 a3  e0..e3                               ef     ip
        vecs[0] = mk(4'b1111, 0, 1, 2, 3,  0, 1, 2, 3,                     32'h0,   0, 1, 2, 3,  0, 1, 2, 3,                          32'h0,   32'h0);
        vecs[1] = mk(4'b0001, 0, 9, 9, 9,  4, 32'hdead, 32'hdead, 32'hdead, 32'h0,  0, 1, 2, 3,  4, 1, 2, 3,                          32'h0,   32'h0);
        vecs[2] = mk(4'b1111, 7, 7, 7, 7,  10, 11, 12, 13,                 32'h0,   7, 7, 7, 7,  13, 13, 13, 13,                      32'h0,   32'h0);
        vecs[3] = mk(4'b0000, 30, 31, 0, 1, 1, 2, 3, 4,                    32'hA5,  30, 7, 0, 1, 32'hA5, 13, 4, 1,                    32'hA5,  32'h0);
        vecs[4] = mk(4'b0010, 0, 30, 0, 0, 0, 32'h55, 0, 0,                32'hFF,  30, 31, 7, 3, 32'h55, 0, 13, 3,                   32'h55,  32'h0);
        vecs[5] = mk(4'b0100, 0, 0, 31, 0, 0, 0, 32'h100, 0,               32'hFF,  31, 30, 2, 0, 32'h100, 32'hFF, 2, 4,              32'hFF,  32'h100);
        vecs[6] = mk(4'b1001, 30, 0, 0, 30, 1, 9, 9, 2,                    32'h77,  30, 31, 7, 1, 2, 32'h100, 13, 1,                  32'h2,   32'h100);
        vecs[7] = mk(4'b0110, 0, 31, 31, 0, 0, 32'hAAA, 32'hBBB, 0,        32'h0,   31, 30, 5, 6, 32'hBBB, 0, 0, 0,                   32'h0,   32'hBBB);

        // Reset with no clock edge involved.
        #2;
        bus.select_a_i = {5'd5, 5'd4, 5'd3, 5'd2};
        arst = 1'b1;
        #1;
        check_all_zero("reset");
        $display("reset asserted: a_o=%h ip=%h flags=%h", bus.a_o, bus.instr_ptr_o, bus.flags_o);
        @(negedge clk);
        arst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            bus.enable_writing_i = vecs[i].en;
            bus.select_r_i = vecs[i].sel_r;
            bus.data_i     = vecs[i].data;
            bus.flags_i    = vecs[i].flags;
            bus.select_a_i = vecs[i].sel_a;
            bus.select_b_i = vecs[i].sel_a;
            bus.select_c_i = {vecs[i].sel_a[1], vecs[i].sel_a[0]};
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("vec%0d a_o[%0d]", i, k), bus.a_o[k], vecs[i].exp_a[k]);
                chk($sformatf("vec%0d b_o[%0d]", i, k), bus.b_o[k], vecs[i].exp_a[k]);
            end
            for (int k = 0; k < 2; k++)
                chk($sformatf("vec%0d c_o[%0d]", i, k), bus.c_o[k], vecs[i].exp_a[k]);
            chk($sformatf("vec%0d flags_o", i), bus.flags_o, vecs[i].exp_flags);
            chk($sformatf("vec%0d instr_ptr_o", i), bus.instr_ptr_o, vecs[i].exp_ip);
            $display("vec %0d: en=%b a_o=%h flags=%h ip=%h", i, vecs[i].en, bus.a_o, bus.flags_o, bus.instr_ptr_o);
        end

        // Async reset pulse between edges while a write is pending.
        #2;
        bus.enable_writing_i = 4'b0001;
        bus.select_r_i = {5'd0, 5'd0, 5'd0, 5'd5};
        bus.data_i     = {32'h0, 32'h0, 32'h0, 32'h99};
        bus.flags_i    = 32'h11;
        bus.select_a_i = {5'd0, 5'd7, 5'd30, 5'd31};
        arst = 1'b1;
        #1;
        check_all_zero("midreset");
        bus.select_a_i = {5'd0, 5'd7, 5'd30, 5'd5};
        @(posedge clk);
        #1;
        check_all_zero("held_reset_edge");
        #2;
        arst = 1'b0;
        #1;
        check_all_zero("after_release");
        @(posedge clk);
        #1;
        chk("post_reset reg5", bus.a_o[0], 32'h99);
        chk("post_reset flags_o", bus.flags_o, 32'h11);
        chk("post_reset reg7", bus.a_o[2], 32'h0);
        chk("post_reset instr_ptr_o", bus.instr_ptr_o, 32'h0);
        $display("reset pulse: a_o=%h flags=%h ip=%h", bus.a_o, bus.flags_o, bus.instr_ptr_o);

        for (int r = 0; r < 32; r++) model[r] = 32'h0;
        model[5]   = 32'h99;
        model[FLX] = 32'h11;

        // Random traffic; narrow address windows now and then force conflicts
        // and hits on the IP/FLAGS registers.
        for (int it = 0; it < 200; it++) begin
            int mode;
            mode = $urandom_range(0, 2);
            bus.enable_writing_i = 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                case (mode)
                    0:       bus.select_r_i[k] = 5'($urandom_range(0, 31));
                    1:       bus.select_r_i[k] = 5'($urandom_range(0, 3));
                    default: bus.select_r_i[k] = 5'($urandom_range(28, 31));
                endcase
                bus.data_i[k] = $urandom;
            end
            bus.flags_i = $urandom;
            @(posedge clk);
            model[FLX] = bus.flags_i;
            for (int k = 0; k < 4; k++)
                if (bus.enable_writing_i[k]) model[bus.select_r_i[k]] = bus.data_i[k];
            #1;
            check_model_reads(it);
            $display("rnd %0d: en=%b sel_r=%h ip=%h flags=%h", it, bus.enable_writing_i,
                     bus.select_r_i, bus.instr_ptr_o, bus.flags_o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_rf_32x_regfile
